wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave port, such as the I2C master core's register interface, among NUM_MASTERS independent Wishbone masters, such as test agents or on-chip sequencers. It grants the bus for whole cycles (cyc-framed) and muxes the granted master onto the slave. A per-transfer watchdog aborts stalled slave accesses with an error pulse so that a hung slave cannot lock the bus.

## Interface
- NUM_MASTERS, 4, number of requesting masters (2..8)
- ADDR_WIDTH, 32, Wishbone address width
- DATA_WIDTH, 16, Wishbone data width
- TIMEOUT_CYCLES, 256, max wait cycles for s_ack_i per strobe; 0 disables watchdog
- clk_i  in  1  system clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at slice k
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_ack_o  out  NUM_MASTERS  ack, routed to granted master only
- m_err_o  out  NUM_MASTERS  timeout error pulse to granted master
- m_dat_o  out  DATA_WIDTH  read data, s_dat_i broadcast to all masters
- gnt_o  out  NUM_MASTERS  one-hot registered grant; all zero when idle
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  ADDR_WIDTH  to slave
- s_dat_o  out  DATA_WIDTH  to slave
- s_ack_i  in  1  slave ack
- s_dat_i  in  DATA_WIDTH  slave read data

## Operation
- States: IDLE, BUSY, ABORT.
- IDLE: if any m_cyc_i is high, pick the first requester scanning from last+1 upward, wrapping modulo NUM_MASTERS. Register it in gnt_o and last, then go to BUSY. With no request, remain in IDLE with gnt_o = 0.
- BUSY, granted master g:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o and s_dat_o combinationally follow master g.
  - m_ack_o[g] = s_ack_i. All other acks are 0.
  - Multiple strobes within one cyc are allowed.
- BUSY exit: m_cyc_i[g] low leads to IDLE, with gnt_o cleared on the same clock edge. The arbiter never preempts a master.
- Watchdog counter:
  - Clears on entry to BUSY and on every s_ack_i.
  - Increments while s_stb_o && !s_ack_i.
  - When the count reaches TIMEOUT_CYCLES, pulse m_err_o[g] for one cycle and enter ABORT.
- ABORT: s_cyc_o and s_stb_o are forced to 0 and m_ack_o is all 0. The arbiter waits for m_cyc_i[g] low, then goes to IDLE.
- Non-granted masters see ack and err held at 0, so they wait indefinitely.
- Reset values: gnt_o = 0, last = NUM_MASTERS-1 (master 0 wins first), state = IDLE, counter = 0. All s_* control outputs are 0 and all m_ack_o/m_err_o are 0. s_adr_o and s_dat_o are 0 when idle.

## Timing
- Arbitration latency: 1 clock. A request sampled high at edge N gives gnt_o and slave-side cyc from edge N onward, i.e. visible in cycle N+1.
- Ack path: combinational from s_ack_i, zero added latency. A single-wait slave therefore completes as it would stand-alone.
- Release to regrant: m_cyc_i[g] low at edge N sends the arbiter to IDLE. The next grant registers at edge N+1. There is a minimum of one idle bus cycle between owners.
- Simultaneous requests from all masters: grants rotate 0,1,2,3,0,… when each master holds cyc for one transfer.
- Master drops cyc while its strobe is pending: the access is abandoned and the arbiter goes to IDLE. The slave sees cyc fall.
- s_ack_i in the same cycle the counter would reach TIMEOUT_CYCLES: the ack wins and no error is raised.
- rst_i high mid-transfer: at the next edge all outputs take their reset values, regardless of state.

## Structure
- wb_arb_pkg holds:
  - the arb_state_t enum (IDLE, BUSY, ABORT)
  - MAX_MASTERS = 8
  - the counter-width function clog2(TIMEOUT_CYCLES+1)
- Sub-module rr_picker: given the request vector and last, it returns a one-hot next grant and its index (purely combinational rotate-and-priority). Instantiated once.

## Test plan
- After reset, master 2 writes addr 0x1 data 0x00C5. Required: gnt_o=4'b0100 after 1 clk, slave sees adr 0x1, dat 0x00C5, we=1; m_ack_o[2] pulses; gnt_o returns to 0.
- Masters 0–3 request together, one read each. Required: grant order 0,1,2,3; each read returns its slave data on m_dat_o with that master's ack only.
- Master 1 holds cyc for 3 back-to-back writes while master 0 requests. Required: master 1 keeps the grant for all 3; master 0 is granted 1 idle cycle after master 1 drops cyc.
- TIMEOUT_CYCLES=8 and the slave never acks master 3's read. Required: m_err_o[3] pulses 8 cycles after stb, s_cyc_o falls, and the grant clears after master 3 drops cyc.
- rst_i is asserted for 1 clk while master 1 is in BUSY. Required: all outputs are 0 next cycle; with master 0 and master 1 requesting afterwards, master 0 is granted first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } arb_state_t;

    localparam int MAX_MASTERS = 8;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester scanning upward from last+1, wrapping.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       idx,
    output logic                   valid
);

    always_comb begin
        int k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            k = (int'(last) + i) % NUM_MASTERS;
            if (!valid && req[k]) begin
                valid  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: cyc-framed grants, slave mux and per-strobe ack watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            gnt_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic                              s_ack_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t             state_q, state_n;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_n;
    logic [IDX_W-1:0]       last_q, last_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic [NUM_MASTERS-1:0] err_q, err_n;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    rr_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    // last_q doubles as the granted index while BUSY/ABORT; an ack on the
    // final counted cycle takes priority over the timeout.
    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        err_n   = '0;
        case (state_q)
            IDLE: begin
                gnt_n = '0;
                cnt_n = '0;
                if (pick_valid) begin
                    gnt_n   = pick_gnt;
                    last_n  = pick_idx;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!m_cyc_i[last_q]) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end else if (s_ack_i) begin
                    cnt_n = '0;
                end else if (m_stb_i[last_q] && (TIMEOUT_CYCLES != 0)) begin
                    if (cnt_q == CNT_LIMIT) begin
                        err_n[last_q] = 1'b1;
                        cnt_n         = '0;
                        state_n       = ABORT;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            ABORT: begin
                if (!m_cyc_i[last_q]) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (state_q == BUSY) begin
            s_cyc_o         = m_cyc_i[last_q];
            s_stb_o         = m_stb_i[last_q];
            s_we_o          = m_we_i[last_q];
            s_adr_o         = m_adr_i[int'(last_q)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o         = m_dat_i[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
            m_ack_o[last_q] = s_ack_i;
        end
    end

    assign m_err_o = err_q;
    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: per-cycle vectors checked through a scoreboard queue.
module tb_wb_rr_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0020;
    localparam logic [31:0] A2 = 32'h0000_0001;
    localparam logic [31:0] A3 = 32'h0000_0040;
    localparam logic [15:0] D0 = 16'h1111;
    localparam logic [15:0] D1 = 16'h2222;
    localparam logic [15:0] D2 = 16'h00C5;
    localparam logic [15:0] D3 = 16'h4444;
    localparam logic [127:0] ADRS = {A3, A2, A1, A0};
    localparam logic [63:0]  DATS = {D3, D2, D1, D0};

    typedef struct packed {
        logic        rst;
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic [3:0]  we;
        logic        ack;
        logic [15:0] sdat;
        logic [3:0]  gnt;
        logic [3:0]  mack;
        logic [3:0]  merr;
        logic        scyc;
        logic        sstb;
        logic        swe;
        logic [31:0] sadr;
        logic [15:0] sdato;
    } vec_t;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [3:0]  mack;
        logic [3:0]  merr;
        logic        scyc;
        logic        sstb;
        logic        swe;
        logic [31:0] sadr;
        logic [15:0] sdato;
        logic [15:0] mdat;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [127:0] m_adr_i;
    logic [63:0]  m_dat_i;
    logic [3:0]   m_ack_o, m_err_o, gnt_o;
    logic [15:0]  m_dat_o;
    logic         s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]  s_adr_o;
    logic [15:0]  s_dat_o;
    logic         s_ack_i;
    logic [15:0]  s_dat_i;

    exp_t  expQ[$];
    string nameQ[$];
    vec_t  table1[$];
    string phase;
    int    rowNum = 0;
    int    checks = 0;
    int    errors = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS   (4),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .m_cyc_i(m_cyc_i),
        .m_stb_i(m_stb_i),
        .m_we_i (m_we_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .m_dat_o(m_dat_o),
        .gnt_o  (gnt_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o (s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i),
        .s_dat_i(s_dat_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [3:0] s,
                                input logic [3:0] w, input logic a, input logic [15:0] sd,
                                input logic [3:0] g, input logic [3:0] ma, input logic [3:0] me,
                                input logic sc, input logic ss, input logic sw,
                                input logic [31:0] ad, input logic [15:0] dd);
        vec_t v;
        v.rst = r;  v.cyc = c;  v.stb = s;  v.we = w;  v.ack = a;  v.sdat = sd;
        v.gnt = g;  v.mack = ma; v.merr = me;
        v.scyc = sc; v.sstb = ss; v.swe = sw; v.sadr = ad; v.sdato = dd;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what the DUT must show.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i   = v.rst;
        m_cyc_i = v.cyc;
        m_stb_i = v.stb;
        m_we_i  = v.we;
        s_ack_i = v.ack;
        s_dat_i = v.sdat;
        e.gnt = v.gnt;  e.mack = v.mack; e.merr = v.merr;
        e.scyc = v.scyc; e.sstb = v.sstb; e.swe = v.swe;
        e.sadr = v.sadr; e.sdato = v.sdato; e.mdat = v.sdat;
        rowNum++;
        expQ.push_back(e);
        nameQ.push_back($sformatf("%s row %0d", phase, rowNum));
    endtask

    task automatic checkOutput();
        exp_t  e;
        exp_t  a;
        string n;
        @(negedge clk_i);
        e = expQ.pop_front();
        n = nameQ.pop_front();
        a.gnt = gnt_o;  a.mack = m_ack_o; a.merr = m_err_o;
        a.scyc = s_cyc_o; a.sstb = s_stb_o; a.swe = s_we_o;
        a.sadr = s_adr_o; a.sdato = s_dat_o; a.mdat = m_dat_o;
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b ack=%b err=%b cyc=%b stb=%b we=%b adr=%h dat=%h mdat=%h, expected gnt=%b ack=%b err=%b cyc=%b stb=%b we=%b adr=%h dat=%h mdat=%h",
                     n, a.gnt, a.mack, a.merr, a.scyc, a.sstb, a.swe, a.sadr, a.sdato, a.mdat,
                     e.gnt, e.mack, e.merr, e.scyc, e.sstb, e.swe, e.sadr, e.sdato, e.mdat);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        vec_t idle;
        logic [3:0] pending;
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = ADRS;
        m_dat_i = DATS;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        idle = mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);

        // Single write by master 2 straight after reset.
        table1.push_back(idle);
        table1.push_back(mk(1'b0, 4'h4, 4'h4, 4'h4, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        table1.push_back(mk(1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 16'h0, 4'h4, 4'h4, 4'h0, 1'b1, 1'b1, 1'b1, A2, D2));
        table1.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, A2, D2));
        table1.push_back(idle);
        phase = "single_write";
        doReset();
        foreach (table1[i]) runVec(table1[i]);

        // All four masters request at once, one read each.
        phase = "rotate";
        doReset();
        pending = 4'hF;
        for (int i = 0; i < 4; i++) begin
            runVec(mk(1'b0, pending, pending, 4'h0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
            runVec(mk(1'b0, pending, pending, 4'h0, 1'b1, 16'hA000 + 16'(i), 4'(1 << i), 4'(1 << i), 4'h0,
                      1'b1, 1'b1, 1'b0, ADRS[i*32 +: 32], DATS[i*16 +: 16]));
            pending[i] = 1'b0;
            runVec(mk(1'b0, pending, pending, 4'h0, 1'b0, 16'h0, 4'(1 << i), 4'h0, 4'h0,
                      1'b0, 1'b0, 1'b0, ADRS[i*32 +: 32], DATS[i*16 +: 16]));
        end
        runVec(idle);

        // Master 1 keeps the bus for three writes while master 0 waits.
        phase = "no_preempt";
        doReset();
        runVec(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h3, 4'h3, 4'h2, 1'b1, 16'h0, 4'h2, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, A1, D1));
        runVec(mk(1'b0, 4'h3, 4'h1, 4'h2, 1'b0, 16'h0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, A1, D1));
        runVec(mk(1'b0, 4'h3, 4'h3, 4'h2, 1'b1, 16'h0, 4'h2, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, A1, D1));
        runVec(mk(1'b0, 4'h3, 4'h3, 4'h2, 1'b1, 16'h0, 4'h2, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, A1, D1));
        runVec(mk(1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 16'h0, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, A1, D1));
        runVec(mk(1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 16'h5A5A, 4'h1, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, A0, D0));
        runVec(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, A0, D0));
        runVec(idle);

        // Slave never acks master 3: error after 8 waiting cycles, then abort.
        phase = "timeout";
        doReset();
        runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        for (int i = 0; i < 8; i++)
            runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, A3, D3));
        runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(idle);

        // Ack arriving on the cycle that would hit the limit beats the timeout.
        phase = "ack_wins";
        runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        for (int i = 0; i < 7; i++)
            runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, A3, D3));
        runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 16'h3C3C, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b0, A3, D3));
        runVec(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, A3, D3));
        runVec(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, A3, D3));
        runVec(idle);

        // Reset pulse while master 1 owns the bus, then master 0 must win first.
        phase = "mid_reset";
        doReset();
        runVec(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b0, 16'h0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, A1, D1));
        runVec(mk(1'b1, 4'h2, 4'h2, 4'h2, 1'b0, 16'h0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, A1, D1));
        runVec(mk(1'b0, 4'h3, 4'h3, 4'h2, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h3, 4'h3, 4'h2, 1'b1, 16'h0BAD, 4'h1, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, A0, D0));
        runVec(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b0, 16'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, A0, D0));
        runVec(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0));
        runVec(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b1, 16'h0, 4'h2, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, A1, D1));
        runVec(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, A1, D1));
        runVec(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
